median_window_gen: RTL and testbench

Producer side of the median column-sort network. Accepts a raster pixel stream, buffers two previous image lines, and presents a 4-column x 3-row window on the twelve outputs x2_y1 .. xm1_ym1 that the sort network consumes. The outputs use a registered valid/ready handshake. The block sits between the pixel source (camera/DMA) and the combinational sort/median stages.

---
 rtl/median_pkg.sv | 32 +++
 rtl/median_line_buffer.sv | 27 ++
 rtl/median_window_gen.sv | 146 ++++++++++++++
 tb/tb_median_window_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants for the median window generator and sort network.
// Pixel width default, counter widths and window index map.
package median_pkg;

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DATA_W    = 8;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int COL_W     = cnt_w(IMG_W_DEF);
  localparam int ROW_W     = cnt_w(IMG_H_DEF);

  // Window index map: row-major, oldest row first, oldest column first.
  localparam int WIN_X2_Y1   = 0;
  localparam int WIN_X1_Y1   = 1;
  localparam int WIN_X0_Y1   = 2;
  localparam int WIN_XM1_Y1  = 3;
  localparam int WIN_X2_Y0   = 4;
  localparam int WIN_X1_Y0   = 5;
  localparam int WIN_X0_Y0   = 6;
  localparam int WIN_XM1_Y0  = 7;
  localparam int WIN_X2_YM1  = 8;
  localparam int WIN_X1_YM1  = 9;
  localparam int WIN_X0_YM1  = 10;
  localparam int WIN_XM1_YM1 = 11;
  localparam int WIN_N       = 12;
  localparam int WIN_ROWS    = 3;
  localparam int WIN_COLS    = 4;

endpackage

// File: rtl/median_line_buffer.sv
// Single-port line RAM with read-before-write at a shared address.
// Read is combinational on the address; the write lands on the edge.
module median_line_buffer
  import median_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 640
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [cnt_w(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // Store the new column sample; the old word is already on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/median_window_gen.sv
// Raster stream to 4x3 window generator for the median sort network.
// Two line buffers, three column shifters, registered valid/ready output.
module median_window_gen
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int IMG_WIDTH  = IMG_W_DEF,
  parameter int IMG_HEIGHT = IMG_H_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  pix_valid,
  input  logic                  pix_sof,
  output logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] x2_y1,
  output logic [DATA_WIDTH-1:0] x1_y1,
  output logic [DATA_WIDTH-1:0] x0_y1,
  output logic [DATA_WIDTH-1:0] xm1_y1,
  output logic [DATA_WIDTH-1:0] x2_y0,
  output logic [DATA_WIDTH-1:0] x1_y0,
  output logic [DATA_WIDTH-1:0] x0_y0,
  output logic [DATA_WIDTH-1:0] xm1_y0,
  output logic [DATA_WIDTH-1:0] x2_ym1,
  output logic [DATA_WIDTH-1:0] x1_ym1,
  output logic [DATA_WIDTH-1:0] x0_ym1,
  output logic [DATA_WIDTH-1:0] xm1_ym1,
  output logic                  win_valid,
  output logic                  win_last,
  input  logic                  win_ready
);

  localparam int CW = cnt_w(IMG_WIDTH);
  localparam int RW = cnt_w(IMG_HEIGHT);
  localparam int DW = DATA_WIDTH;

  logic [CW-1:0] col, cur_col, nxt_col;
  logic [RW-1:0] row, cur_row, nxt_row;
  logic          accept, last_col, last_row, hit;

  logic [2*DW-1:0] lb_rd, lb_wr;
  logic [DW-1:0]   smp [WIN_ROWS];
  logic [DW-1:0]   sr  [WIN_ROWS][WIN_COLS];
  logic [DW-1:0]   nsr [WIN_ROWS][WIN_COLS];
  logic [DW-1:0]   win [WIN_N];

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // A start-of-frame pixel is taken as (0,0) whatever the counters say.
  assign cur_col  = pix_sof ? '0 : col;
  assign cur_row  = pix_sof ? '0 : row;
  assign last_col = (cur_col == CW'(IMG_WIDTH - 1));
  assign last_row = (cur_row == RW'(IMG_HEIGHT - 1));
  assign nxt_col  = last_col ? '0 : cur_col + 1'b1;
  assign nxt_row  = !last_col ? cur_row :
                    last_row  ? '0 : cur_row + 1'b1;

  assign hit = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(3));

  // Low half is the line above, high half the line two above.
  assign lb_wr  = {lb_rd[DW-1:0], pix_data};
  assign smp[0] = lb_rd[2*DW-1:DW];
  assign smp[1] = lb_rd[DW-1:0];
  assign smp[2] = pix_data;

  median_line_buffer #(
    .WIDTH (2 * DW),
    .DEPTH (IMG_WIDTH)
  ) u_lb (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata (lb_wr),
    .rdata (lb_rd)
  );

  // Next state of the column shifters for the pixel being accepted.
  always_comb begin
    for (int r = 0; r < WIN_ROWS; r++) begin
      for (int k = 0; k < WIN_COLS - 1; k++) begin
        nsr[r][k] = sr[r][k+1];
      end
      nsr[r][WIN_COLS-1] = smp[r];
    end
  end

  // Raster position counters advance only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

  // Column shifters; stale columns at line start are masked by gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        for (int k = 0; k < WIN_COLS; k++) begin
          sr[r][k] <= '0;
        end
      end
    end else if (accept) begin
      sr <= nsr;
    end
  end

  // Output window register: load on a full window, drop when consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN_N; i++) begin
        win[i] <= '0;
      end
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (hit) begin
      for (int r = 0; r < WIN_ROWS; r++) begin
        for (int k = 0; k < WIN_COLS; k++) begin
          win[r*WIN_COLS+k] <= nsr[r][k];
        end
      end
      win_valid <= 1'b1;
      win_last  <= last_row && last_col;
    end else if (win_ready) begin
      win_valid <= 1'b0;
    end
  end

  assign x2_y1   = win[WIN_X2_Y1];
  assign x1_y1   = win[WIN_X1_Y1];
  assign x0_y1   = win[WIN_X0_Y1];
  assign xm1_y1  = win[WIN_XM1_Y1];
  assign x2_y0   = win[WIN_X2_Y0];
  assign x1_y0   = win[WIN_X1_Y0];
  assign x0_y0   = win[WIN_X0_Y0];
  assign xm1_y0  = win[WIN_XM1_Y0];
  assign x2_ym1  = win[WIN_X2_YM1];
  assign x1_ym1  = win[WIN_X1_YM1];
  assign x0_ym1  = win[WIN_X0_YM1];
  assign xm1_ym1 = win[WIN_XM1_YM1];

endmodule

// File: tb/tb_median_window_gen.sv
// Directed bench for median_window_gen on an 8x4 image.
// Pixel value = offset + row*16 + col; windows collected by a monitor.
module tb_median_window_gen;

  localparam int DW = 8;
  localparam int IW = 8;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_data;
  logic          pix_valid, pix_sof, pix_ready;
  logic [DW-1:0] x2_y1, x1_y1, x0_y1, xm1_y1;
  logic [DW-1:0] x2_y0, x1_y0, x0_y0, xm1_y0;
  logic [DW-1:0] x2_ym1, x1_ym1, x0_ym1, xm1_ym1;
  logic          win_valid, win_last, win_ready;

  int total = 0;
  int bad   = 0;

  logic [95:0] got_q[$];
  logic [95:0] exp_q[$];
  bit          got_l[$];
  bit          exp_l[$];

  median_window_gen #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_ready (pix_ready),
    .x2_y1     (x2_y1),
    .x1_y1     (x1_y1),
    .x0_y1     (x0_y1),
    .xm1_y1    (xm1_y1),
    .x2_y0     (x2_y0),
    .x1_y0     (x1_y0),
    .x0_y0     (x0_y0),
    .xm1_y0    (xm1_y0),
    .x2_ym1    (x2_ym1),
    .x1_ym1    (x1_ym1),
    .x0_ym1    (x0_ym1),
    .xm1_ym1   (xm1_ym1),
    .win_valid (win_valid),
    .win_last  (win_last),
    .win_ready (win_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] cur_win();
    return {xm1_ym1, x0_ym1, x1_ym1, x2_ym1,
            xm1_y0, x0_y0, x1_y0, x2_y0,
            xm1_y1, x0_y1, x1_y1, x2_y1};
  endfunction

  // Window whose newest pixel sits at (r,c): rows r-2..r, cols c-3..c.
  function automatic logic [95:0] exp_win(input int off, input int r,
                                          input int c);
    logic [95:0] w;
    w = '0;
    for (int ri = 0; ri < 3; ri++) begin
      for (int ci = 0; ci < 4; ci++) begin
        w[(ri*4+ci)*8 +: 8] = 8'(off + (r - 2 + ri) * 16 + (c - 3 + ci));
      end
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [95:0] got,
                     input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (win_valid && win_ready) begin
      got_q.push_back(cur_win());
      got_l.push_back(win_last);
    end
  end

  task automatic exp_frame(input int off);
    for (int r = 2; r < IH; r++) begin
      for (int c = 3; c < IW; c++) begin
        exp_q.push_back(exp_win(off, r, c));
        exp_l.push_back(r == IH - 1 && c == IW - 1);
      end
    end
  endtask

  task automatic cmp_q(input string tag);
    int n;
    chk({tag, "_cnt"}, 96'(got_q.size()), 96'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
      chk($sformatf("%s_l%0d", tag, i), 96'(got_l[i]), 96'(exp_l[i]));
    end
    got_q.delete();
    exp_q.delete();
    got_l.delete();
    exp_l.delete();
  endtask

  task automatic push(input int d, input bit s, input bit bub);
    bit acc;
    if (bub) begin
      for (int k = 0; k < 3 && $urandom_range(1, 0) == 1; k++) begin
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    pix_data  = 8'(d);
    pix_sof   = s;
    pix_valid = 1'b1;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = pix_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("push_timeout", 96'(acc), 96'(1));
    pix_sof = 1'b0;
  endtask

  task automatic send(input int off, input int first, input int last,
                      input bit sof, input bit bub);
    for (int i = first; i < last; i++) begin
      push(off + (i / IW) * 16 + (i % IW), sof && i == 0, bub);
    end
  endtask

  task automatic idle(input int n);
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    got_q.delete();
    got_l.delete();
  endtask

  initial begin
    rst       = 1'b1;
    pix_data  = '0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    win_ready = 1'b1;
    do_reset();

    chk("rst_valid", 96'(win_valid), 96'(0));
    chk("rst_last", 96'(win_last), 96'(0));
    chk("rst_win", cur_win(), 96'(0));
    chk("rst_ready", 96'(pix_ready), 96'(1));

    // Basic frame with latency probe around the first window.
    send(0, 0, 19, 1'b1, 1'b0);
    chk("lat_pre", 96'(win_valid), 96'(0));
    push(8'h23, 1'b0, 1'b0);
    chk("lat_valid", 96'(win_valid), 96'(1));
    chk("first_x2_y1", 96'(x2_y1), 96'(8'h00));
    chk("first_x0_y0", 96'(x0_y0), 96'(8'h12));
    chk("first_xm1_ym1", 96'(xm1_ym1), 96'(8'h23));
    send(0, 20, 32, 1'b0, 1'b0);
    chk("last_xm1_ym1", 96'(xm1_ym1), 96'(8'h37));
    chk("last_flag", 96'(win_last), 96'(1));
    idle(4);
    exp_frame(0);
    cmp_q("basic");

    // Backpressure right after the first window.
    do_reset();
    send(0, 0, 20, 1'b1, 1'b0);
    win_ready = 1'b0;
    pix_data  = 8'h24;
    pix_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_ready%0d", k), 96'(pix_ready), 96'(0));
      chk($sformatf("bp_hold%0d", k), cur_win(), exp_win(0, 2, 3));
      @(posedge clk);
      #1;
    end
    win_ready = 1'b1;
    push(8'h24, 1'b0, 1'b0);
    chk("bp_next", 96'(xm1_ym1), 96'(8'h24));
    send(0, 21, 32, 1'b0, 1'b0);
    idle(4);
    exp_frame(0);
    cmp_q("bp");

    // Input bubbles.
    do_reset();
    send(0, 0, 32, 1'b1, 1'b1);
    idle(4);
    exp_frame(0);
    cmp_q("bub");

    // Abort at row 2 col 5 with a start-of-frame of a new frame.
    do_reset();
    send(0, 0, 21, 1'b1, 1'b0);
    send(8'h80, 0, 32, 1'b1, 1'b0);
    idle(4);
    exp_q.push_back(exp_win(0, 2, 3));
    exp_l.push_back(1'b0);
    exp_q.push_back(exp_win(0, 2, 4));
    exp_l.push_back(1'b0);
    exp_frame(8'h80);
    cmp_q("sof");

    // Reset at row 3 col 4, then a frame without sof.
    do_reset();
    send(0, 0, 28, 1'b1, 1'b0);
    rst       = 1'b1;
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_valid", 96'(win_valid), 96'(0));
    chk("mrst_win", cur_win(), 96'(0));
    got_q.delete();
    got_l.delete();
    send(0, 0, 32, 1'b0, 1'b0);
    idle(4);
    exp_frame(0);
    cmp_q("mrst");

    // Two back-to-back frames.
    do_reset();
    send(0, 0, 32, 1'b1, 1'b0);
    send(8'h80, 0, 32, 1'b1, 1'b0);
    idle(4);
    exp_frame(0);
    exp_frame(8'h80);
    cmp_q("b2b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
